mont_mul_param: RTL and testbench



---
 rtl/mont_mul_defines.sv | 37 +++
 rtl/mont_mul_core.sv | 108 ++++++++++
 rtl/mont_mul_param.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mont_mul_param.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mont_mul_defines.sv
// mont_mul_defines: shared definitions for the parametrised Montgomery multiplier.
//   - FSM state encoding (3 bits)
//   - load-target selector for the datapath core
//   - WORD_BYTES and a word-address helper (wraps modulo 2^32)
//   - `DATA_WORD, the LSU access type; taken from riscv_defines when that is
//     compiled first, otherwise given the word encoding here.
`ifndef DATA_WORD
`define DATA_WORD 2'b00
`endif

package mont_mul_defines;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_FETCH_N = 3'd3,
    ST_RUN     = 3'd4,
    ST_REDUCE  = 3'd5,
    ST_STORE   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2,
    SEL_N    = 2'd3
  } load_sel_t;

  // Byte address of word idx of an operand; 32-bit add wraps naturally.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx * 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/mont_mul_core.sv
// mont_mul_core: operand registers and arithmetic of the Montgomery multiplier.
//   clk, rst        clock, synchronous active-high reset
//   clear           zero the accumulator M (start of an operation)
//   load, load_sel  write load_data into word load_idx of A, B or N
//   load_dup        with SEL_A, also write the word into B (squaring)
//   step            one radix-2 iteration: M' = (M + a0*B + q*N)/2, A >>= 1
//   reduce          M = M - N when M >= N
//   rd_idx/rd_word  word of M selected for the write-back
//   red_word0       word 0 of the reduced value (first store word)
//   m_low           M[NBITS-1:0], only with MONT_MUL_RESULT_BUS_EN defined
module mont_mul_core
  import mont_mul_defines::*;
#(
  parameter int WORDS = 4,
  localparam int NBITS = WORDS * 32,
  localparam int IW = $clog2(WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  load_sel_t       load_sel,
  input  logic            load_dup,
  input  logic [IW-1:0]   load_idx,
  input  logic [31:0]     load_data,
  input  logic            step,
  input  logic            reduce,
  input  logic [IW-1:0]   rd_idx,
  output logic [31:0]     rd_word,
`ifdef MONT_MUL_RESULT_BUS_EN
  output logic [NBITS-1:0] m_low,
`endif
  output logic [31:0]     red_word0
);

  logic [NBITS-1:0] a_r;
  logic [NBITS-1:0] b_r;
  logic [NBITS-1:0] n_r;
  logic [NBITS+1:0] m_r;
  logic [NBITS+1:0] t_s;
  logic [NBITS+1:0] m_step_s;
  logic [NBITS+1:0] m_reduced_s;

  // One iteration. t+N is even when t is odd (N odd), so (t+N)/2 is
  // computed as t/2 + N/2 + 1 without a wider intermediate.
  always_comb begin
    t_s = m_r;
    if (a_r[0]) begin
      t_s = m_r + {2'b00, b_r};
    end else begin
      t_s = m_r;
    end
    if (t_s[0]) begin
      m_step_s = {1'b0, t_s[NBITS+1:1]} + {3'b000, n_r[NBITS-1:1]} + (NBITS+2)'(1);
    end else begin
      m_step_s = {1'b0, t_s[NBITS+1:1]};
    end
  end

  // Final conditional subtraction, unsigned over NBITS+2 bits.
  always_comb begin
    if (m_r >= {2'b00, n_r}) begin
      m_reduced_s = m_r - {2'b00, n_r};
    end else begin
      m_reduced_s = m_r;
    end
  end

  // Write-back word selection.
  always_comb begin
    rd_word   = m_r[{rd_idx, 5'd0} +: 32];
    red_word0 = m_reduced_s[31:0];
  end

`ifdef MONT_MUL_RESULT_BUS_EN
  assign m_low = m_r[NBITS-1:0];
`endif

  // Operand and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      n_r <= '0;
      m_r <= '0;
    end else if (clear) begin
      m_r <= '0;
    end else if (load) begin
      case (load_sel)
        SEL_A: begin
          a_r[{load_idx, 5'd0} +: 32] <= load_data;
          if (load_dup) begin
            b_r[{load_idx, 5'd0} +: 32] <= load_data;
          end
        end
        SEL_B:   b_r[{load_idx, 5'd0} +: 32] <= load_data;
        SEL_N:   n_r[{load_idx, 5'd0} +: 32] <= load_data;
        default: m_r <= m_r;
      endcase
    end else if (step) begin
      m_r <= m_step_s;
      a_r <= a_r >> 1;
    end else if (reduce) begin
      m_r <= m_reduced_s;
    end
  end

endmodule

// File: rtl/mont_mul_param.sv
// mont_mul_param: R = A*B*2^(-NBITS) mod N, NBITS = WORDS*32, over an LSU port.
// Operands are fetched word by word (little-endian word order), the product is
// built by NBITS radix-2 iterations, reduced once and written back.
//   start/sqr           begin (sampled in IDLE only); sqr reuses A as B
//   a/b/n/res_addr      operand and result base addresses
//   lsu_ren/lsu_wen     read / write request, held until lsu_done
//   lsu_type            constant `DATA_WORD
//   lsu_addr/lsu_wdata  registered, stable while a request is pending
//   lsu_done/lsu_rdata  one-cycle acknowledge, read data valid with it
//   busy                high outside IDLE
//   done                one-cycle completion pulse
//   result              M[NBITS-1:0], present when MONT_MUL_RESULT_BUS_EN is defined
module mont_mul_param
  import mont_mul_defines::*;
#(
  parameter int WORDS = 4,
  localparam int NBITS = WORDS * 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sqr,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       n_addr,
  input  logic [31:0]       res_addr,
  output logic              lsu_ren,
  output logic              lsu_wen,
  output logic [1:0]        lsu_type,
  output logic [31:0]       lsu_addr,
  input  logic              lsu_done,
  input  logic [31:0]       lsu_rdata,
  output logic [31:0]       lsu_wdata,
`ifdef MONT_MUL_RESULT_BUS_EN
  output logic [NBITS-1:0]  result,
`endif
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(WORDS);
  localparam int BW = $clog2(NBITS + 1);

  state_t        state_r, state_s;
  logic [IW-1:0] w_r, w_s, w_inc_s;
  logic [BW-1:0] bit_r, bit_s;
  logic [31:0]   a_base_r, b_base_r, n_base_r, res_base_r;
  logic          sqr_r;
  logic          ren_r, ren_s, wen_r, wen_s, busy_r, busy_s, done_r, done_s;
  logic [31:0]   addr_r, addr_s, wdata_r, wdata_s;
  logic          last_w_s;
  logic          latch_s, clear_s, load_s, step_s, reduce_s;
  load_sel_t     sel_s;
  logic [31:0]   rd_word_s, red_word0_s;

  mont_mul_core #(.WORDS(WORDS)) u_core (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .load      (load_s),
    .load_sel  (sel_s),
    .load_dup  (sqr_r),
    .load_idx  (w_r),
    .load_data (lsu_rdata),
    .step      (step_s),
    .reduce    (reduce_s),
    .rd_idx    (w_inc_s),
    .rd_word   (rd_word_s),
`ifdef MONT_MUL_RESULT_BUS_EN
    .m_low     (result),
`endif
    .red_word0 (red_word0_s)
  );

  assign lsu_type  = `DATA_WORD;
  assign lsu_ren   = ren_r;
  assign lsu_wen   = wen_r;
  assign lsu_addr  = addr_r;
  assign lsu_wdata = wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Word index helpers.
  always_comb begin
    w_inc_s  = w_r + IW'(1);
    last_w_s = (w_r == IW'(WORDS - 1));
  end

  // Next state, datapath strobes and next values of the registered LSU outputs.
  // Requests stay high across fetch phases so each word costs one cycle with a
  // zero-wait LSU; only after the last N word does ren drop.
  always_comb begin
    state_s  = state_r;
    w_s      = w_r;
    bit_s    = bit_r;
    ren_s    = 1'b0;
    wen_s    = 1'b0;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    done_s   = 1'b0;
    latch_s  = 1'b0;
    clear_s  = 1'b0;
    load_s   = 1'b0;
    sel_s    = SEL_NONE;
    step_s   = 1'b0;
    reduce_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          latch_s = 1'b1;
          clear_s = 1'b1;
          w_s     = '0;
          state_s = ST_FETCH_A;
          ren_s   = 1'b1;
          addr_s  = a_addr;
        end else begin
          addr_s  = 32'h0000_0000;
          wdata_s = 32'h0000_0000;
        end
      end
      ST_FETCH_A: begin
        ren_s = 1'b1;
        if (lsu_done) begin
          load_s = 1'b1;
          sel_s  = SEL_A;
          if (last_w_s) begin
            w_s = '0;
            if (sqr_r) begin
              state_s = ST_FETCH_N;
              addr_s  = n_base_r;
            end else begin
              state_s = ST_FETCH_B;
              addr_s  = b_base_r;
            end
          end else begin
            w_s    = w_inc_s;
            addr_s = word_addr(a_base_r, 32'(w_inc_s));
          end
        end else begin
          addr_s = addr_r;
        end
      end
      ST_FETCH_B: begin
        ren_s = 1'b1;
        if (lsu_done) begin
          load_s = 1'b1;
          sel_s  = SEL_B;
          if (last_w_s) begin
            w_s     = '0;
            state_s = ST_FETCH_N;
            addr_s  = n_base_r;
          end else begin
            w_s    = w_inc_s;
            addr_s = word_addr(b_base_r, 32'(w_inc_s));
          end
        end else begin
          addr_s = addr_r;
        end
      end
      ST_FETCH_N: begin
        ren_s = 1'b1;
        if (lsu_done) begin
          load_s = 1'b1;
          sel_s  = SEL_N;
          if (last_w_s) begin
            w_s     = '0;
            ren_s   = 1'b0;
            bit_s   = '0;
            state_s = ST_RUN;
            addr_s  = 32'h0000_0000;
          end else begin
            w_s    = w_inc_s;
            addr_s = word_addr(n_base_r, 32'(w_inc_s));
          end
        end else begin
          addr_s = addr_r;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (bit_r == BW'(NBITS - 1)) begin
          bit_s   = '0;
          state_s = ST_REDUCE;
        end else begin
          bit_s = bit_r + BW'(1);
        end
      end
      ST_REDUCE: begin
        // First store word comes from the reduced value, which M only
        // holds after this edge.
        reduce_s = 1'b1;
        state_s  = ST_STORE;
        w_s      = '0;
        wen_s    = 1'b1;
        addr_s   = res_base_r;
        wdata_s  = red_word0_s;
      end
      ST_STORE: begin
        wen_s = 1'b1;
        if (lsu_done) begin
          if (last_w_s) begin
            wen_s   = 1'b0;
            done_s  = 1'b1;
            w_s     = '0;
            state_s = ST_IDLE;
            addr_s  = 32'h0000_0000;
            wdata_s = 32'h0000_0000;
          end else begin
            w_s     = w_inc_s;
            addr_s  = word_addr(res_base_r, 32'(w_inc_s));
            wdata_s = rd_word_s;
          end
        end else begin
          addr_s  = addr_r;
          wdata_s = wdata_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Control state, latched operands and registered LSU/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      w_r        <= '0;
      bit_r      <= '0;
      a_base_r   <= 32'h0000_0000;
      b_base_r   <= 32'h0000_0000;
      n_base_r   <= 32'h0000_0000;
      res_base_r <= 32'h0000_0000;
      sqr_r      <= 1'b0;
      ren_r      <= 1'b0;
      wen_r      <= 1'b0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      w_r     <= w_s;
      bit_r   <= bit_s;
      ren_r   <= ren_s;
      wen_r   <= wen_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      if (latch_s) begin
        a_base_r   <= a_addr;
        b_base_r   <= b_addr;
        n_base_r   <= n_addr;
        res_base_r <= res_addr;
        sqr_r      <= sqr;
      end
    end
  end

endmodule

// File: tb/tb_mont_mul_param.sv
// tb_mont_mul_param: directed bench for mont_mul_param. A WORDS=4 instance
// runs against a zero-wait memory, a WORDS=2 instance against a memory that
// acknowledges on the fourth cycle of each request.
module tb_mont_mul_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // WORDS=4 instance
  logic        start4, sqr4, ren4, wen4, done_in4, busy4, done4, force_done4;
  logic [31:0] aa4, ba4, na4, ra4, addr4, wdata4, rdata4;
  logic [1:0]  type4;
  // WORDS=2 instance
  logic        start2, sqr2, ren2, wen2, done_in2, busy2, done2;
  logic [31:0] aa2, ba2, na2, ra2, addr2, wdata2, rdata2;
  logic [1:0]  type2;
`ifdef MONT_MUL_RESULT_BUS_EN
  logic [127:0] result4;
  logic [63:0]  result2;
`endif

  mont_mul_param #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sqr(sqr4),
    .a_addr(aa4), .b_addr(ba4), .n_addr(na4), .res_addr(ra4),
    .lsu_ren(ren4), .lsu_wen(wen4), .lsu_type(type4), .lsu_addr(addr4),
    .lsu_done(done_in4), .lsu_rdata(rdata4), .lsu_wdata(wdata4),
`ifdef MONT_MUL_RESULT_BUS_EN
    .result(result4),
`endif
    .busy(busy4), .done(done4)
  );

  mont_mul_param #(.WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sqr(sqr2),
    .a_addr(aa2), .b_addr(ba2), .n_addr(na2), .res_addr(ra2),
    .lsu_ren(ren2), .lsu_wen(wen2), .lsu_type(type2), .lsu_addr(addr2),
    .lsu_done(done_in2), .lsu_rdata(rdata2), .lsu_wdata(wdata2),
`ifdef MONT_MUL_RESULT_BUS_EN
    .result(result2),
`endif
    .busy(busy2), .done(done2)
  );

  // Shared word memory, indexed by addr[9:2]; the only writer is the clocked block.
  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;
  int          cnt2 = 0, reads4 = 0, bad_b4 = 0, unstable2 = 0, stalls2 = 0;
  logic        stall2 = 1'b0, pwen2 = 1'b0;
  logic [31:0] paddr2 = 32'd0, pwdata2 = 32'd0;

  assign done_in4 = ren4 | wen4 | force_done4;
  assign done_in2 = (ren2 | wen2) && (cnt2 == 3);
  assign rdata4   = mem[addr4[9:2]];
  assign rdata2   = mem[addr2[9:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (wen4 && done_in4) mem[addr4[9:2]] <= wdata4;
    if (wen2 && done_in2) mem[addr2[9:2]] <= wdata2;
    if (ren4 && done_in4) reads4 <= reads4 + 1;
    if (ren4 && addr4 == 32'hDEAD_0000) bad_b4 <= bad_b4 + 1;
    if ((ren2 | wen2) && !done_in2) cnt2 <= cnt2 + 1;
    else cnt2 <= 0;
    if ((ren2 | wen2) && !done_in2) begin
      stall2 <= 1'b1; paddr2 <= addr2; pwdata2 <= wdata2; pwen2 <= wen2;
      stalls2 <= stalls2 + 1;
    end else begin
      stall2 <= 1'b0;
    end
    if (stall2 && (addr2 != paddr2 || (pwen2 && wdata2 != pwdata2)))
      unstable2 <= unstable2 + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_words(input int idx, input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      pl_en = 1'b1; pl_idx = 8'(idx + i); pl_data = v[32*i +: 32];
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
  endtask

  function automatic logic [127:0] rd_mem(input int idx, input int n);
    logic [127:0] v = '0;
    for (int i = 0; i < n; i++) v[32*i +: 32] = mem[idx + i];
    return v;
  endfunction

  task automatic start_run4(input logic [31:0] a, b, n, r, input logic s);
    aa4 = a; ba4 = b; na4 = n; ra4 = r; sqr4 = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait_done4(inout int cyc);
    while (done4 !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
  endtask

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] SENT = {4{32'hFFFF_FFFF}};

  initial begin
    int cyc;
    int r0, b0;
    rst = 1'b1; force_done4 = 1'b0;
    start4 = 1'b0; sqr4 = 1'b0; aa4 = '0; ba4 = '0; na4 = '0; ra4 = '0;
    start2 = 1'b0; sqr2 = 1'b0; aa2 = '0; ba2 = '0; na2 = '0; ra2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_busy", 128'(busy4), 128'd0);
    check("rst_ren",  128'(ren4),  128'd0);
    check("rst_wen",  128'(wen4),  128'd0);
    check("rst_done", 128'(done4), 128'd0);
    check("rst_addr", 128'(addr4), 128'd0);
    check("rst_busy2", 128'(busy2), 128'd0);

    // stray acknowledge in IDLE
    force_done4 = 1'b1; @(posedge clk); #1; force_done4 = 1'b0;
    @(posedge clk); #1;
    check("idle_ack_busy", 128'(busy4), 128'd0);
    check("idle_ack_ren",  128'(ren4),  128'd0);

    // 3*5 with N = 2^128-1
    load_words(64, 128'd3, 4);
    load_words(80, 128'd5, 4);
    load_words(96, ONES, 4);
    load_words(112, SENT, 4);
    load_words(128, SENT, 4);
    start_run4(32'h100, 32'h140, 32'h180, 32'h1C0, 1'b0);
    check("t1_busy", 128'(busy4), 128'd1);
    cyc = 0; wait_done4(cyc);
    check("t1_cycles", 128'(cyc), 128'd145);
    check("t1_result", rd_mem(112, 4), 128'd15);
`ifdef MONT_MUL_RESULT_BUS_EN
    check("t1_result_bus", result4, 128'd15);
`endif
    @(posedge clk); #1;
    check("t1_done_pulse", 128'(done4), 128'd0);
    check("t1_busy_end", 128'(busy4), 128'd0);

    // (N-1)^2 -> 1, needs the final subtraction
    load_words(64, ONES - 128'd1, 4);
    load_words(80, ONES - 128'd1, 4);
    start_run4(32'h100, 32'h140, 32'h180, 32'h1C0, 1'b0);
    cyc = 0; wait_done4(cyc);
    check("t2_cycles", 128'(cyc), 128'd145);
    check("t2_result", rd_mem(112, 4), 128'd1);

    // squaring 7 -> 49, B never fetched
    load_words(64, 128'd7, 4);
    r0 = reads4; b0 = bad_b4;
    start_run4(32'h100, 32'hDEAD_0000, 32'h180, 32'h1C0, 1'b1);
    cyc = 0; wait_done4(cyc);
    check("t3_cycles", 128'(cyc), 128'd141);
    check("t3_result", rd_mem(112, 4), 128'd49);
    check("t3_reads", 128'(reads4 - r0), 128'd8);
    check("t3_b_reads", 128'(bad_b4 - b0), 128'd0);

    // WORDS=2, stalled LSU, 2^32 * 2^32 mod 2^64-1
    load_words(160, 128'h1_0000_0000, 2);
    load_words(168, 128'h1_0000_0000, 2);
    load_words(176, 128'hFFFF_FFFF_FFFF_FFFF, 2);
    load_words(184, SENT, 2);
    aa2 = 32'h280; ba2 = 32'h2A0; na2 = 32'h2C0; ra2 = 32'h2E0; sqr2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    check("t4_cycles", 128'(cyc), 128'd97);
    check("t4_result", rd_mem(184, 2), 128'd1);
    check("t4_unstable", 128'(unstable2), 128'd0);
    check("t4_stalls_seen", 128'(stalls2 > 0), 128'd1);

    // reset in the middle of RUN, then a clean run
    load_words(64, 128'd3, 4);
    load_words(80, 128'd5, 4);
    load_words(112, SENT, 4);
    start_run4(32'h100, 32'h140, 32'h180, 32'h1C0, 1'b0);
    repeat (49) begin @(posedge clk); #1; end
    rst = 1'b1; @(posedge clk); #1;
    check("t5_busy", 128'(busy4), 128'd0);
    check("t5_ren",  128'(ren4),  128'd0);
    check("t5_wen",  128'(wen4),  128'd0);
    check("t5_no_write", rd_mem(112, 4), SENT);
    rst = 1'b0;
    start_run4(32'h100, 32'h140, 32'h180, 32'h1C0, 1'b0);
    cyc = 0; wait_done4(cyc);
    check("t5_cycles", 128'(cyc), 128'd145);
    check("t5_result", rd_mem(112, 4), 128'd15);

    // start during FETCH_N with other addresses is ignored
    load_words(112, SENT, 4);
    load_words(128, SENT, 4);
    start_run4(32'h100, 32'h140, 32'h180, 32'h1C0, 1'b0);
    cyc = 0;
    repeat (9) begin @(posedge clk); #1; cyc++; end
    aa4 = 32'h240; ba4 = 32'h240; na4 = 32'h240; ra4 = 32'h200; start4 = 1'b1;
    @(posedge clk); #1; cyc++;
    start4 = 1'b0;
    wait_done4(cyc);
    check("t6_cycles", 128'(cyc), 128'd145);
    check("t6_result", rd_mem(112, 4), 128'd15);
    check("t6_alt_untouched", rd_mem(128, 4), SENT);
    @(posedge clk); #1;
    check("t6_idle_after", 128'(busy4), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
